// File: rtl/intr_ctrl_apb.sv
// APB-programmable priority interrupt controller with a valid/serviced CPU handshake.
// Define INTR_CTRL_EDGE_EN to latch sources on rising edges (W1C PENDING); level-sensitive otherwise.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding, waiting for any eligible source
// ARB   | sample the winner onto intr_id/intr_prio and raise intr_valid
// WAIT  | request presented and frozen until intr_serviced

module intr_ctrl_apb #(
    parameter int NUM_SRC    = 16,
    parameter int PRIO_WIDTH = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
    input  logic                  pclk,
    input  logic                  prst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [NUM_SRC-1:0]    intr_active,
    output logic                  intr_valid,
    output logic [ID_WIDTH-1:0]   intr_id,
    output logic [PRIO_WIDTH-1:0] intr_prio,
    input  logic                  intr_serviced
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE  = ADDR_WIDTH'(NUM_SRC);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PENDING = ADDR_WIDTH'(NUM_SRC + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(NUM_SRC + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
    logic [NUM_SRC-1:0]    enable_q;
    logic [NUM_SRC-1:0]    pending_q;
    logic [NUM_SRC-1:0]    eligible;
    logic                  any_eligible;
    logic [ID_WIDTH-1:0]   win_id;
    logic [PRIO_WIDTH-1:0] win_prio;
    logic                  load_win;
    logic                  clear_out;
    logic                  setup_phase;
    logic                  addr_err;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_pwdata;

    assign unused_pwdata = ^pwdata;

    // Response is registered from the setup phase so pready is high exactly in the access cycle.
    assign setup_phase = psel & ~penable;
    assign addr_err    = (paddr > ADDR_STATUS);
    assign wr_en       = psel & penable & pwrite & ~addr_err;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
        end else if (wr_en && (paddr < ADDR_ENABLE)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (paddr == ADDR_WIDTH'(i)) begin
                    prio_q[i] <= pwdata[PRIO_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            enable_q <= '0;
        end else if (wr_en && (paddr == ADDR_ENABLE)) begin
            enable_q <= pwdata[NUM_SRC-1:0];
        end
    end

`ifdef INTR_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] active_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_clr;

    always_comb begin
        rise     = intr_active & ~active_q;
        pend_clr = '0;
        if (wr_en && (paddr == ADDR_PENDING)) begin
            pend_clr = pwdata[NUM_SRC-1:0];
        end
        if ((state_q == ST_WAIT) && intr_serviced) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (intr_id == ID_WIDTH'(i)) begin
                    pend_clr[i] = 1'b1;
                end
            end
        end
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            active_q  <= '0;
            pending_q <= '0;
        end else begin
            active_q  <= intr_active;
            pending_q <= (pending_q & ~pend_clr) | rise;
        end
    end
`else
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= intr_active;
        end
    end
`endif

    // Strict greater-than while scanning upwards gives ties to the lowest index.
    always_comb begin
        eligible = '0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] != '0);
            if (eligible[i] && (prio_q[i] > win_prio)) begin
                win_prio = prio_q[i];
                win_id   = ID_WIDTH'(i);
            end
        end
    end

    assign any_eligible = |eligible;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_win  = 1'b0;
        clear_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (any_eligible) begin
                    load_win = 1'b1;
                    state_d  = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (intr_serviced) begin
                    clear_out = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            intr_valid <= 1'b0;
            intr_id    <= '0;
            intr_prio  <= '0;
        end else if (load_win) begin
            intr_valid <= 1'b1;
            intr_id    <= win_id;
            intr_prio  <= win_prio;
        end else if (clear_out) begin
            intr_valid <= 1'b0;
            intr_id    <= '0;
            intr_prio  <= '0;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (paddr == ADDR_WIDTH'(i)) begin
                rd_data = DATA_WIDTH'(prio_q[i]);
            end
        end
        if (paddr == ADDR_ENABLE) begin
            rd_data = DATA_WIDTH'(enable_q);
        end
        if (paddr == ADDR_PENDING) begin
            rd_data = DATA_WIDTH'(pending_q);
        end
        if (paddr == ADDR_STATUS) begin
            rd_data = DATA_WIDTH'({intr_valid, intr_prio, intr_id});
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else if (setup_phase) begin
            pready  <= 1'b1;
            pslverr <= addr_err;
            prdata  <= addr_err ? '0 : rd_data;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end
    end

endmodule

// File: tb/tb_intr_ctrl_apb.sv
// Directed bench for intr_ctrl_apb (default parameters); edge-mode steps build with INTR_CTRL_EDGE_EN.
module tb_intr_ctrl_apb;

    localparam int NUM_SRC    = 16;
    localparam int PRIO_WIDTH = 4;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int A_EN   = 16;
    localparam int A_PEND = 17;
    localparam int A_STAT = 18;
    localparam int A_BAD  = 19;

    logic                  pclk;
    logic                  prst_n;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;
    logic [NUM_SRC-1:0]    intr_active;
    logic                  intr_valid;
    logic [ID_WIDTH-1:0]   intr_id;
    logic [PRIO_WIDTH-1:0] intr_prio;
    logic                  intr_serviced;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;
    logic        err;
    logic        rdy;

    intr_ctrl_apb #(
        .NUM_SRC(NUM_SRC), .PRIO_WIDTH(PRIO_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .pclk(pclk), .prst_n(prst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .intr_active(intr_active), .intr_valid(intr_valid), .intr_id(intr_id),
        .intr_prio(intr_prio), .intr_serviced(intr_serviced)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input int addr, input logic [31:0] data, output logic err_o);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = ADDR_WIDTH'(addr); pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        err_o = pslverr;
        chk("wr_pready", pready, 1);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input int addr, output logic [31:0] data, output logic err_o,
                            output logic rdy_o);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ADDR_WIDTH'(addr);
        @(negedge pclk);
        penable = 1'b1;
        data = prdata; err_o = pslverr; rdy_o = pready;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        prst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; intr_active = '0; intr_serviced = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_valid", intr_valid, 0);
        chk("rst_id", intr_id, 0);
        chk("rst_prio", intr_prio, 0);
        chk("rst_pready", pready, 0);
        chk("rst_pslverr", pslverr, 0);
        prst_n = 1'b1;

        apb_read(3, rd, err, rdy);
        chk("rst_prio3", rd, 0);
        chk("rd_pready", rdy, 1);
        chk("rd_pslverr", err, 0);
        apb_read(A_EN, rd, err, rdy);
        chk("rst_enable", rd, 0);
        apb_read(A_PEND, rd, err, rdy);
        chk("rst_pending", rd, 0);

        // Two sources, higher priority wins; latency two cycles after pending.
        apb_write(3, 32'd5, err);
        apb_write(9, 32'd7, err);
        apb_write(A_EN, 32'h0208, err);
        intr_active = 16'h0208;
        @(negedge pclk);
        chk("lat_k", intr_valid, 0);
        @(negedge pclk);
        chk("lat_k1", intr_valid, 0);
        @(negedge pclk);
        chk("lat_k2_valid", intr_valid, 1);
        chk("win_id9", intr_id, 9);
        chk("win_prio7", intr_prio, 7);
        apb_read(A_STAT, rd, err, rdy);
        chk("status_9", rd, 32'h179);
        apb_read(A_PEND, rd, err, rdy);
        chk("pending_3_9", rd, 32'h0208);

        // Service and drop source 9: source 3 follows two cycles later.
        @(negedge pclk);
        intr_serviced = 1'b1; intr_active = 16'h0008;
        @(negedge pclk);
        intr_serviced = 1'b0;
        chk("svc_valid", intr_valid, 0);
        chk("svc_id", intr_id, 0);
        chk("svc_prio", intr_prio, 0);
        @(negedge pclk);
        chk("svc_m1", intr_valid, 0);
        @(negedge pclk);
        chk("svc_m2_valid", intr_valid, 1);
        chk("win_id3", intr_id, 3);
        chk("win_prio5", intr_prio, 5);

        // Outputs frozen in WAIT despite register changes.
        apb_write(A_EN, 32'h0, err);
        apb_write(3, 32'd1, err);
        chk("frz_valid", intr_valid, 1);
        chk("frz_id", intr_id, 3);
        chk("frz_prio", intr_prio, 5);
        @(negedge pclk);
        intr_serviced = 1'b1; intr_active = 16'h0;
        @(negedge pclk);
        intr_serviced = 1'b0;
        chk("frz_svc", intr_valid, 0);
        repeat (4) @(negedge pclk);
        chk("dis_idle", intr_valid, 0);
        apb_read(3, rd, err, rdy);
        chk("prio3_new", rd, 1);

        // Equal priorities: lowest index wins; priority 0 is never presented.
        apb_write(2, 32'd4, err);
        apb_write(6, 32'd4, err);
        apb_write(A_EN, 32'h0044, err);
        intr_active = 16'h0044;
        repeat (3) @(negedge pclk);
        chk("tie_valid", intr_valid, 1);
        chk("tie_id", intr_id, 2);
        chk("tie_prio", intr_prio, 4);
        apb_write(6, 32'd0, err);
        chk("tie_frz_id", intr_id, 2);
        @(negedge pclk);
        intr_serviced = 1'b1; intr_active = 16'h0040;
        @(negedge pclk);
        intr_serviced = 1'b0;
        chk("tie_svc", intr_valid, 0);
        repeat (5) @(negedge pclk);
        chk("prio0_never", intr_valid, 0);
        apb_read(A_STAT, rd, err, rdy);
        chk("status_idle", rd, 0);

        // Out-of-range word address.
        apb_read(A_BAD, rd, err, rdy);
        chk("bad_rd_err", err, 1);
        chk("bad_rd_data", rd, 0);
        chk("bad_rd_rdy", rdy, 1);
        apb_write(A_BAD, 32'hFFFF_FFFF, err);
        chk("bad_wr_err", err, 1);
        apb_read(A_EN, rd, err, rdy);
        chk("bad_wr_enable", rd, 32'h0044);
        apb_read(3, rd, err, rdy);
        chk("bad_wr_prio3", rd, 1);

`ifdef INTR_CTRL_EDGE_EN
        // One-cycle pulse on source 5 is latched until serviced.
        apb_write(5, 32'd3, err);
        apb_write(A_EN, 32'h0020, err);
        intr_active = 16'h0060;
        @(negedge pclk);
        intr_active = 16'h0040;
        repeat (2) @(negedge pclk);
        chk("edge_valid", intr_valid, 1);
        chk("edge_id", intr_id, 5);
        chk("edge_prio", intr_prio, 3);
        apb_read(A_PEND, rd, err, rdy);
        chk("edge_pend_held", rd, 32'h0060);
        @(negedge pclk);
        intr_serviced = 1'b1;
        @(negedge pclk);
        intr_serviced = 1'b0;
        chk("edge_svc", intr_valid, 0);
        apb_read(A_PEND, rd, err, rdy);
        chk("edge_pend_clr", rd, 32'h0040);

        // New edge in the same cycle as service keeps the bit set.
        intr_active = 16'h0060;
        @(negedge pclk);
        intr_active = 16'h0040;
        repeat (2) @(negedge pclk);
        chk("edge2_id", intr_id, 5);
        intr_serviced = 1'b1; intr_active = 16'h0060;
        @(negedge pclk);
        intr_serviced = 1'b0; intr_active = 16'h0040;
        chk("edge2_svc", intr_valid, 0);
        apb_read(A_PEND, rd, err, rdy);
        chk("set_wins", rd, 32'h0060);

        // W1C clears PENDING but the presented request stays frozen.
        apb_write(A_PEND, 32'h0020, err);
        chk("w1c_err", err, 0);
        apb_read(A_PEND, rd, err, rdy);
        chk("w1c_pend", rd, 32'h0040);
        chk("w1c_frz_valid", intr_valid, 1);
        chk("w1c_frz_id", intr_id, 5);
        @(negedge pclk);
        intr_serviced = 1'b1;
        @(negedge pclk);
        intr_serviced = 1'b0;
        repeat (3) @(negedge pclk);
        chk("w1c_idle", intr_valid, 0);
`else
        // Level mode: PENDING mirrors the lines and ignores writes.
        apb_write(A_PEND, 32'h0000_FFFF, err);
        chk("lvl_pend_wr_err", err, 0);
        apb_read(A_PEND, rd, err, rdy);
        chk("lvl_pend", rd, 32'h0040);
`endif

        // Asynchronous reset in the middle of WAIT.
        apb_write(1, 32'd2, err);
        apb_write(A_EN, 32'h0002, err);
        intr_active = 16'h0042;
        repeat (3) @(negedge pclk);
        chk("pre_rst_valid", intr_valid, 1);
        chk("pre_rst_id", intr_id, 1);
        chk("pre_rst_prio", intr_prio, 2);
        #2 prst_n = 1'b0;
        #1;
        chk("async_valid", intr_valid, 0);
        chk("async_id", intr_id, 0);
        chk("async_prio", intr_prio, 0);
        @(negedge pclk);
        prst_n = 1'b1;
        apb_read(1, rd, err, rdy);
        chk("post_rst_prio1", rd, 0);
        apb_read(A_EN, rd, err, rdy);
        chk("post_rst_enable", rd, 0);
        repeat (4) @(negedge pclk);
        chk("post_rst_valid", intr_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
